// File: rtl/ascon_pkg.sv
// Ascon shared definitions: widths, round constants, rotations,
// mode encodings and the 320-bit state bundle.
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int WORD_W  = 64;
    localparam int ROUNDS  = 12;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Entries 12..15 follow the same {~i, i} rule and are never selected by p12.
    localparam logic [7:0] RC [16] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
        8'h78, 8'h69, 8'h5a, 8'h4b, 8'h3c, 8'h2d, 8'h1e, 8'h0f
    };

    localparam int unsigned ROT0A = 19;
    localparam int unsigned ROT0B = 28;
    localparam int unsigned ROT1A = 61;
    localparam int unsigned ROT1B = 39;
    localparam int unsigned ROT2A = 1;
    localparam int unsigned ROT2B = 6;
    localparam int unsigned ROT3A = 10;
    localparam int unsigned ROT3B = 17;
    localparam int unsigned ROT4A = 7;
    localparam int unsigned ROT4B = 41;

    typedef enum logic {
        IDLE,
        RUN
    } fin_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] x0;
        logic [WORD_W-1:0] x1;
        logic [WORD_W-1:0] x2;
        logic [WORD_W-1:0] x3;
        logic [WORD_W-1:0] x4;
    } ascon_state_t;

    function automatic logic [WORD_W-1:0] ror(
        input logic [WORD_W-1:0] w,
        input int unsigned       n
    );
        return (w >> n) | (w << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant add, bitsliced 5-bit
// S-box, linear diffusion. Shared by any iterative pN driver.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [WORD_W-1:0] x0,
    input  logic [WORD_W-1:0] x1,
    input  logic [WORD_W-1:0] x2,
    input  logic [WORD_W-1:0] x3,
    input  logic [WORD_W-1:0] x4,
    input  logic [7:0]        rc,
    output logic [WORD_W-1:0] x0n,
    output logic [WORD_W-1:0] x1n,
    output logic [WORD_W-1:0] x2n,
    output logic [WORD_W-1:0] x3n,
    output logic [WORD_W-1:0] x4n
);

    logic [WORD_W-1:0] a0, a1, a2, a3, a4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    logic [WORD_W-1:0] s0, s1, s2, s3, s4;

    always_comb begin
        a0 = x0 ^ x4;
        a1 = x1;
        a2 = x2 ^ {56'd0, rc} ^ x1;
        a3 = x3;
        a4 = x4 ^ x3;

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        // chi output followed by the affine post-layer of the S-box
        s0 = a0 ^ t1 ^ a4 ^ t0;
        s1 = a1 ^ t2 ^ a0 ^ t1;
        s2 = ~(a2 ^ t3);
        s3 = a3 ^ t4 ^ a2 ^ t3;
        s4 = a4 ^ t0;
    end

    assign x0n = s0 ^ ror(s0, ROT0A) ^ ror(s0, ROT0B);
    assign x1n = s1 ^ ror(s1, ROT1A) ^ ror(s1, ROT1B);
    assign x2n = s2 ^ ror(s2, ROT2A) ^ ror(s2, ROT2B);
    assign x3n = s3 ^ ror(s3, ROT3A) ^ ror(s3, ROT3B);
    assign x4n = s4 ^ ror(s4, ROT4A) ^ ror(s4, ROT4B);

endmodule

// File: rtl/ascon_finalize.sv
// Ascon-128a finalization: key mix, iterative p12 at one round per
// cycle, tag extraction and decrypt-side tag compare.
module ascon_finalize
    import ascon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              final_start,
    input  logic              final_mode_sel,
    input  logic [127:0]      key_in,
    input  logic [127:0]      tag_in,
    input  logic [WORD_W-1:0] x0_i,
    input  logic [WORD_W-1:0] x1_i,
    input  logic [WORD_W-1:0] x2_i,
    input  logic [WORD_W-1:0] x3_i,
    input  logic [WORD_W-1:0] x4_i,
    output logic              busy,
    output logic              done,
    output logic [127:0]      tag_out,
    output logic              tag_match,
    output logic              final_err
);

    localparam logic [3:0] RC_LAST = 4'(ROUNDS - 1);

    fin_state_t         fsm, fsm_nxt;
    logic [3:0]         rcnt;
    logic [STATE_W-1:0] st_q;
    ascon_state_t       st, sn;
    logic [127:0]       key_q, tag_in_q, tag_nxt;
    logic               mode_q;
    logic               load, step, last, err_nxt;

    assign st = st_q;

    ascon_round u_round (
        .x0  (st.x0),
        .x1  (st.x1),
        .x2  (st.x2),
        .x3  (st.x3),
        .x4  (st.x4),
        .rc  (RC[rcnt]),
        .x0n (sn.x0),
        .x1n (sn.x1),
        .x2n (sn.x2),
        .x3n (sn.x3),
        .x4n (sn.x4)
    );

    assign tag_nxt = {sn.x3 ^ key_q[127:64], sn.x4 ^ key_q[63:0]};
    assign busy    = (fsm == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        err_nxt = 1'b0;
        unique case (fsm)
            IDLE: begin
                if (final_start) begin
                    load    = 1'b1;
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                step    = 1'b1;
                err_nxt = final_start;
                if (rcnt == RC_LAST) begin
                    last    = 1'b1;
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= '0;
            key_q     <= '0;
            tag_in_q  <= '0;
            mode_q    <= MODE_ENC;
            rcnt      <= '0;
            tag_out   <= '0;
            tag_match <= 1'b0;
            done      <= 1'b0;
            final_err <= 1'b0;
        end else begin
            done      <= last;
            final_err <= err_nxt;
            if (load) begin
                st_q     <= {x0_i, x1_i,
                             x2_i ^ key_in[127:64],
                             x3_i ^ key_in[63:0],
                             x4_i};
                key_q    <= key_in;
                tag_in_q <= tag_in;
                mode_q   <= final_mode_sel;
                rcnt     <= '0;
            end else if (step) begin
                st_q <= sn;
                rcnt <= last ? 4'd0 : rcnt + 4'd1;
            end
            if (last) begin
                tag_out   <= tag_nxt;
                tag_match <= (mode_q == MODE_DEC) && (tag_nxt == tag_in_q);
            end
        end
    end

endmodule
